// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
//
// Parametrised serial pattern detector (Mealy). Watches the serial bit
// stream on x and raises z in the same cycle as the final bit of a
// runtime-programmable pattern of 1..PW bits. The reset defaults
// (pattern 101, length 3, overlapping) match the legacy fixed "101"
// overlapping detector.
//
// Optional feature macro: SEQ_DET_HIT_CNT_EN
//   defined   -> a saturating match counter drives hit_cnt, clr clears it
//   undefined -> no counter register is built, hit_cnt is tied to 0 and
//                clr is ignored
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   en        in   1   sample enable, x is consumed only when en=1
//   x         in   1   serial data bit
//   cfg_load  in   1   one-cycle pulse latching cfg_pat/cfg_len/cfg_ovl
//   cfg_pat   in   PW  pattern, bit [len-1] received first, bit 0 last
//   cfg_len   in   LW  pattern length (0 disables matching, >PW clamps)
//   cfg_ovl   in   1   1 = overlapping matches, 0 = non-overlapping
//   clr       in   1   synchronous clear of hit_cnt
//   z         out  1   match flag, combinational from x
//   hit_cnt   out  CW  saturating match count
// ---------------------------------------------------------------------------
module seq_det_param #(
    parameter int              PW      = 8,
    parameter int              LW      = $clog2(PW + 1),
    parameter int              CW      = 8,
    parameter logic [PW-1:0]   DEF_PAT = PW'(8'b0000_0101),
    parameter int              DEF_LEN = 3,
    parameter bit              DEF_OVL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          x,
    input  logic          cfg_load,
    input  logic [PW-1:0] cfg_pat,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_ovl,
    input  logic          clr,
    output logic          z,
    output logic [CW-1:0] hit_cnt
);

    // fill only needs to reach PW-1, so it is one value short of PW
    localparam int            FW       = $clog2(PW);
    localparam logic [FW-1:0] FILL_MAX = FW'(PW - 1);

    logic [PW-1:0] pat_q;
    logic [LW-1:0] len_q;
    logic          ovl_q;
    logic [PW-2:0] hist_q;
    logic [FW-1:0] fill_q;

    logic [LW-1:0] eff_len;
    logic [PW-1:0] window;
    logic [PW-1:0] len_mask;
    logic          fill_ok;
    logic          match;

    // The candidate window is the stored history with the live bit x
    // appended as bit 0, so a match can be flagged in the same cycle as
    // the final pattern bit. Only the low eff_len bits take part in the
    // comparison, and enough bits must have been accepted since the last
    // restart to fill the upper part of that window.
    always_comb begin
        eff_len  = (len_q > LW'(PW)) ? LW'(PW) : len_q;
        window   = {hist_q, x};
        len_mask = '0;
        for (int i = 0; i < PW; i++) begin
            if (i < int'(eff_len)) begin
                len_mask[i] = 1'b1;
            end
        end
        fill_ok = (eff_len != '0) && (int'(fill_q) >= int'(eff_len) - 1);
        match   = ((window ^ pat_q) & len_mask) == '0;
        z       = ~rst & en & ~cfg_load & fill_ok & match;
    end

    // A config load restarts detection from scratch. In non-overlapping
    // mode a match only needs fill cleared; the stale history is masked
    // out by the fill check until it has been fully overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= DEF_PAT;
            len_q  <= LW'(DEF_LEN);
            ovl_q  <= DEF_OVL;
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pat;
            len_q  <= cfg_len;
            ovl_q  <= cfg_ovl;
            hist_q <= '0;
            fill_q <= '0;
        end else if (en) begin
            if (z && !ovl_q) begin
                fill_q <= '0;
            end else begin
                hist_q <= window[PW-2:0];
                fill_q <= (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            end
        end
    end

`ifdef SEQ_DET_HIT_CNT_EN
    logic [CW-1:0] hit_q;

    // Saturating match counter; clr takes priority over a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else if (clr) begin
            hit_q <= '0;
        end else if (z && (hit_q != '1)) begin
            hit_q <= hit_q + CW'(1);
        end
    end

    assign hit_cnt = hit_q;
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign hit_cnt    = '0;
`endif

endmodule
